// File: rtl/alu_arbiter_if.sv
// Request, shared-adder and response signals of the two-requester ALU arbiter.
// slave is the arbiter's view; master is the surrounding requesters and adder.
interface alu_arbiter_if #(
    parameter int CNT_W = 16
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [15:0]      req_a0;
    logic [15:0]      req_b0;
    logic [15:0]      req_a1;
    logic [15:0]      req_b1;
    logic [1:0]       req_mode;
    logic [15:0]      alu_a;
    logic [15:0]      alu_b;
    logic             alu_mode;
    logic [15:0]      alu_sum;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [15:0]      rsp_data;
    logic             rsp_sat;
    logic             rsp_zero;
    logic             rsp_neg;
    logic [CNT_W-1:0] sat_count;
    logic             busy;

    modport slave (
        input  req_valid, req_a0, req_b0, req_a1, req_b1, req_mode, alu_sum, rsp_ready,
        output req_ready, alu_a, alu_b, alu_mode, rsp_valid, rsp_data, rsp_sat,
               rsp_zero, rsp_neg, sat_count, busy
    );

    modport master (
        output req_valid, req_a0, req_b0, req_a1, req_b1, req_mode, alu_sum, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_mode, rsp_valid, rsp_data, rsp_sat,
               rsp_zero, rsp_neg, sat_count, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one 16-bit add/sub datapath between two requesters,
// with signed saturation, result flags and a per-requester response handshake.
//
// state | meaning
// IDLE  | no operation in flight; a pending request is granted this cycle
// EXEC  | latched operands drive the shared adder; result captured at the edge
// RESP  | saturated result held for the owner until it accepts
module alu_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [15:0]      op_a, op_b;
    logic             op_mode, owner, last_grant;
    logic             grant, winner, accept;
    logic [15:0]      b_eff, sat_data, rsp_data_q;
    logic             ovf, rsp_sat_q, rsp_zero_q, rsp_neg_q;
    logic [CNT_W-1:0] sat_count_q;

    // A lone requester always wins; on contention the one not served last wins.
    always_comb begin
        winner = bus.req_valid[1];
        if (bus.req_valid == 2'b11) begin
            winner = ~last_grant;
        end
    end

    assign accept = bus.rsp_ready[owner];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        grant         = 1'b0;
        bus.req_ready = 2'b00;
        bus.rsp_valid = 2'b00;
        case (state)
            IDLE: begin
                if (|bus.req_valid) begin
                    grant                 = 1'b1;
                    bus.req_ready[winner] = 1'b1;
                    state_nxt             = EXEC;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                bus.rsp_valid[owner] = 1'b1;
                if (accept) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latches double as the adder drivers, so alu_* hold outside EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a       <= 16'h0000;
            op_b       <= 16'h0000;
            op_mode    <= 1'b0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
        end else if (grant) begin
            op_a       <= winner ? bus.req_a1 : bus.req_a0;
            op_b       <= winner ? bus.req_b1 : bus.req_b0;
            op_mode    <= bus.req_mode[winner];
            owner      <= winner;
            last_grant <= winner;
        end
    end

    assign b_eff    = op_mode ? ~op_b : op_b;
    assign ovf      = (op_a[15] == b_eff[15]) && (bus.alu_sum[15] != op_a[15]);
    assign sat_data = ovf ? (op_a[15] ? 16'h8000 : 16'h7FFF) : bus.alu_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data_q  <= 16'h0000;
            rsp_sat_q   <= 1'b0;
            rsp_zero_q  <= 1'b0;
            rsp_neg_q   <= 1'b0;
            sat_count_q <= '0;
        end else begin
            if (state == EXEC) begin
                rsp_data_q <= sat_data;
                rsp_sat_q  <= ovf;
                rsp_zero_q <= (sat_data == 16'h0000);
                rsp_neg_q  <= sat_data[15];
            end
            if ((state == RESP) && accept && rsp_sat_q && (sat_count_q != '1)) begin
                sat_count_q <= sat_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign bus.alu_a     = op_a;
    assign bus.alu_b     = op_b;
    assign bus.alu_mode  = op_mode;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_sat   = rsp_sat_q;
    assign bus.rsp_zero  = rsp_zero_q;
    assign bus.rsp_neg   = rsp_neg_q;
    assign bus.sat_count = sat_count_q;
    assign bus.busy      = (state != IDLE);
endmodule
